// File: rtl/uart_rx_fifo_param.sv
// uart_rx_fifo_param: oversampling UART receiver with runtime frame format and a first-word-fall-through FIFO.
// Latency: rx_valid rises 1 clk after the tick that samples the final stop bit.
// Backpressure: none toward the line; a good word arriving while the FIFO is full (and not popped) is dropped with an overrun pulse.
// Ports: clk, rst (async, active-low); tick = oversample enable; rx = serial in; rx_en = start-detect enable;
//   data_bits/stop2/parity_en/parity_odd = frame format, latched when a start bit is detected;
//   rx_data/rx_valid/rx_ready = FIFO head and pop; fifo_count = fill level; rx_busy = frame in progress;
//   frame_err/parity_err/overrun = 1-clk status pulses.
// Optional feature: define UART_RX_PARITY_EN to enable the parity bit; otherwise the parity ports are ignored.
module uart_rx_fifo_param #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   rx,
  input  logic                   rx_en,
  input  logic [2:0]             data_bits,
  input  logic                   stop2,
  input  logic                   parity_en,
  input  logic                   parity_odd,
  output logic [DATA_W-1:0]      rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   rx_busy,
  output logic                   frame_err,
  output logic                   parity_err,
  output logic                   overrun
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_W);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // two-flop synchroniser; idles high so reset never looks like a start bit
  logic rx_meta, rx_s;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // index of the last data bit, clamped to 4..DATA_W-1
  logic [IW-1:0] eff_last;
  always_comb begin
    if (data_bits < 3'd4)                eff_last = IW'(4);
    else if (32'(data_bits) > DATA_W - 1) eff_last = IW'(DATA_W - 1);
    else                                 eff_last = IW'(data_bits);
  end

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n, last_r, last_n;
  logic [DATA_W-1:0] data_r, data_n;
  logic          s2_r, s2_n, second_stop, second_n, ferr_r, ferr_n;
  logic          push, frame_err_n, parity_err_n, par_bad;

`ifdef UART_RX_PARITY_EN
  logic pe_r, pe_n, po_r, po_n, pbit_r, pbit_n;
  // even parity: data XOR parity bit must be 0; odd: must be 1
  assign par_bad = pe_r && ((^data_r ^ pbit_r) != po_r);
`else
  logic unused_parity;
  assign unused_parity = parity_en ^ parity_odd;
  assign par_bad       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      last_r      <= '0;
      data_r      <= '0;
      s2_r        <= 1'b0;
      second_stop <= 1'b0;
      ferr_r      <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_r        <= 1'b0;
      po_r        <= 1'b0;
      pbit_r      <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      last_r      <= last_n;
      data_r      <= data_n;
      s2_r        <= s2_n;
      second_stop <= second_n;
      ferr_r      <= ferr_n;
      frame_err   <= frame_err_n;
      parity_err  <= parity_err_n;
`ifdef UART_RX_PARITY_EN
      pe_r        <= pe_n;
      po_r        <= po_n;
      pbit_r      <= pbit_n;
`endif
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    idx_n        = idx;
    last_n       = last_r;
    data_n       = data_r;
    s2_n         = s2_r;
    second_n     = second_stop;
    ferr_n       = ferr_r;
    push         = 1'b0;
    frame_err_n  = 1'b0;
    parity_err_n = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_n         = pe_r;
    po_n         = po_r;
    pbit_n       = pbit_r;
`endif
    if (tick) begin
      case (state)
        IDLE: begin
          if (rx_en && !rx_s) begin
            state_n  = START;
            cnt_n    = '0;
            idx_n    = '0;
            data_n   = '0;
            second_n = 1'b0;
            ferr_n   = 1'b0;
            last_n   = eff_last;
            s2_n     = stop2;
`ifdef UART_RX_PARITY_EN
            pe_n     = parity_en;
            po_n     = parity_odd;
`endif
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt_n   = '0;   // from here on, full-period samples land mid-bit
            state_n = rx_s ? IDLE : DATA;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt_n       = '0;
            data_n[idx] = rx_s;
            if (idx == last_r) begin
`ifdef UART_RX_PARITY_EN
              state_n = pe_r ? PARITY : STOP;
`else
              state_n = STOP;
`endif
            end else begin
              idx_n = idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == FULL_LAST) begin
            cnt_n   = '0;
            pbit_n  = rx_s;
            state_n = STOP;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == FULL_LAST) begin
            cnt_n = '0;
            if (s2_r && !second_stop) begin
              second_n = 1'b1;
              ferr_n   = ferr_r | !rx_s;
            end else begin
              state_n = IDLE;
              if (ferr_r || !rx_s) frame_err_n  = 1'b1;
              else if (par_bad)    parity_err_n = 1'b1;
              else                 push         = 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign rx_busy = (state != IDLE);

  // FWFT FIFO; a pop in the same clk frees the slot a full-FIFO push needs
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              pop, full, do_push;

  assign rx_valid = (fifo_count != '0);
  assign full     = (fifo_count == (PW + 1)'(DEPTH));
  assign pop      = rx_valid && rx_ready;
  assign do_push  = push && (!full || pop);
  assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_r;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= push && full && !pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!do_push && pop) fifo_count <= fifo_count - 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo_param.sv
module tb_uart_rx_fifo_param;
  localparam int OS = 16;

  logic       clk, rst, tick, rx, rx_en, stop2, parity_en, parity_odd, rx_ready;
  logic [2:0] data_bits;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, parity_err, overrun;
  logic [2:0] fifo_count;

  uart_rx_fifo_param #(.DATA_W(8), .OVERSAMPLE(OS), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx), .rx_en(rx_en), .data_bits(data_bits),
    .stop2(stop2), .parity_en(parity_en), .parity_odd(parity_odd), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .fifo_count(fifo_count), .rx_busy(rx_busy),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  int n_checks = 0, n_fail = 0;
  int n_fe = 0, n_pe = 0, n_ov = 0;
  bit mon_chk = 0;
  logic [7:0] model_q[$];
  int tdiv = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // tick every 4 clks, changed on negedge so it is stable at the sampling posedge
  initial begin
    tick = 0;
    forever begin
      @(negedge clk);
      tdiv = (tdiv + 1) % 4;
      tick = (tdiv == 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // flag pulse counters and, when enabled, pop-side scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (frame_err)  n_fe++;
      if (parity_err) n_pe++;
      if (overrun)    n_ov++;
      if (mon_chk && rx_valid && rx_ready) begin
        if (model_q.size() == 0) chk("unexpected_pop", {24'd0, rx_data}, 32'hFFFF_FFFF);
        else chk("pop_data", {24'd0, rx_data}, {24'd0, model_q.pop_front()});
      end
    end
  end

  task automatic wait_tick();
    @(posedge clk);
    while (!tick) @(posedge clk);
  endtask

  task automatic do_pop();
    @(posedge clk); #1 rx_ready = 1;
    @(posedge clk); #1 rx_ready = 0;
  endtask

  // One frame, each bit held OS ticks. The final stop bit is sampled on the
  // 9th tick edge after it is driven; pop_at_push aligns a single pop there.
  task automatic send_frame(input logic [7:0] d, input int nb, input bit has_par, input logic pbit,
                            input bit two, input logic st1, input logic st2v, input bit pop_at_push);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(d[i]);
    if (has_par) bits.push_back(pbit);
    bits.push_back(st1);
    if (two) bits.push_back(st2v);
    wait_tick();
    for (int k = 0; k < bits.size(); k++) begin
      #1 rx = bits[k];
      if (pop_at_push && k == bits.size() - 1) begin
        repeat (8) wait_tick();
        do begin @(negedge clk); #1; end while (!tick);
        rx_ready = 1;
        wait_tick();
        #1 rx_ready = 0;
        repeat (OS - 9) wait_tick();
      end else begin
        repeat (OS) wait_tick();
      end
    end
    #1 rx = 1;
    repeat (12) wait_tick();
  endtask

  typedef struct {
    logic [7:0] d;
    logic [2:0] db;
    int         nb;
    logic       s2;
    logic       st1;
    logic       st2v;
    logic [7:0] exp_d;
    int         exp_cnt;
    int         exp_fe;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int fe0, pe0, ov0;
    int exp_fe, exp_pe;
    logic [7:0] exp6[4];

    vecs[0] = '{8'hA5, 3'd7, 8, 1'b0, 1'b1, 1'b1, 8'hA5, 1, 0};
    vecs[1] = '{8'h13, 3'd4, 5, 1'b1, 1'b1, 1'b1, 8'h13, 1, 0};
    vecs[2] = '{8'h13, 3'd4, 5, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1};
    vecs[3] = '{8'h1F, 3'd1, 5, 1'b0, 1'b1, 1'b1, 8'h1F, 1, 0};
    vecs[4] = '{8'h5A, 3'd7, 8, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1};
    vecs[5] = '{8'h2C, 3'd5, 6, 1'b0, 1'b1, 1'b1, 8'h2C, 1, 0};
    vecs[6] = '{8'h7F, 3'd6, 7, 1'b0, 1'b1, 1'b1, 8'h7F, 1, 0};
    vecs[7] = '{8'hA5, 3'd7, 8, 1'b1, 1'b0, 1'b1, 8'h00, 0, 1};
    exp6 = '{8'h22, 8'h33, 8'h44, 8'h66};

    rst = 0; rx = 1; rx_en = 1; rx_ready = 0; data_bits = 3'd7;
    stop2 = 0; parity_en = 0; parity_odd = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_flags", {frame_err, parity_err, overrun}, 0);
    @(posedge clk); #1 rst = 1;
    repeat (4) wait_tick();

    // table of single frames
    for (int v = 0; v < 8; v++) begin
      fe0 = n_fe;
      data_bits = vecs[v].db; stop2 = vecs[v].s2;
      send_frame(vecs[v].d, vecs[v].nb, 0, 0, vecs[v].s2, vecs[v].st1, vecs[v].st2v, 0);
      @(negedge clk);
      chk($sformatf("v%0d_count", v), fifo_count, vecs[v].exp_cnt);
      chk($sformatf("v%0d_valid", v), rx_valid, vecs[v].exp_cnt != 0);
      if (vecs[v].exp_cnt != 0) chk($sformatf("v%0d_data", v), rx_data, vecs[v].exp_d);
      chk($sformatf("v%0d_ferr", v), n_fe - fe0, vecs[v].exp_fe);
      chk($sformatf("v%0d_busy", v), rx_busy, 0);
      if (rx_valid) do_pop();
      @(negedge clk);
      chk($sformatf("v%0d_popped", v), fifo_count, 0);
    end

    // short low glitch: false start, back to idle after the half-bit check
    data_bits = 3'd7; stop2 = 0;
    fe0 = n_fe;
    wait_tick(); #1 rx = 0;
    repeat (4) wait_tick(); #1 rx = 1;
    @(negedge clk);
    chk("glitch_busy_hi", rx_busy, 1);
    repeat (8) wait_tick();
    @(negedge clk);
    chk("glitch_busy_lo", rx_busy, 0);
    chk("glitch_count", fifo_count, 0);
    chk("glitch_ferr", n_fe - fe0, 0);

    // start detection disabled
    rx_en = 0;
    send_frame(8'h55, 8, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    chk("rxen_count", fifo_count, 0);
    chk("rxen_busy", rx_busy, 0);
    rx_en = 1;

    // fill, overrun, then simultaneous push+pop while full
    ov0 = n_ov;
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(17 * k), 8, 0, 0, 0, 1, 1, 0);
      @(negedge clk);
      chk($sformatf("fill%0d_count", k), fifo_count, (k < 4) ? k : 4);
    end
    chk("overrun_pulse", n_ov - ov0, 1);
    send_frame(8'h66, 8, 0, 0, 0, 1, 1, 1);
    @(negedge clk);
    chk("pushpop_count", fifo_count, 4);
    chk("pushpop_no_ovr", n_ov - ov0, 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d", k), rx_data, exp6[k]);
      do_pop();
      @(negedge clk);
    end
    chk("drain_count", fifo_count, 0);

    // reset in the middle of DATA with a word held
    send_frame(8'h99, 8, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    chk("prerst_count", fifo_count, 1);
    wait_tick(); #1 rx = 0;
    repeat (40) wait_tick();
    #1 chk("prerst_busy", rx_busy, 1);
    rst = 0;
    #1;
    chk("midrst_busy", rx_busy, 0);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_valid", rx_valid, 0);
    rx = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    repeat (4) wait_tick();
    send_frame(8'h3C, 8, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    chk("postrst_count", fifo_count, 1);
    chk("postrst_data", rx_data, 8'h3C);
    do_pop();

`ifdef UART_RX_PARITY_EN
    parity_en = 1; parity_odd = 0; data_bits = 3'd7;
    pe0 = n_pe;
    send_frame(8'h07, 8, 1, 1'b0, 0, 1, 1, 0);
    @(negedge clk);
    chk("par_bad_pulse", n_pe - pe0, 1);
    chk("par_bad_count", fifo_count, 0);
    send_frame(8'h07, 8, 1, 1'b1, 0, 1, 1, 0);
    @(negedge clk);
    chk("par_good_count", fifo_count, 1);
    chk("par_good_data", rx_data, 8'h07);
    chk("par_good_nopulse", n_pe - pe0, 1);
    do_pop();
    parity_en = 0;
`endif

    // randomized frames against a frame-level model, consumer always ready
    @(negedge clk);
    mon_chk = 1;
    #1 rx_ready = 1;
    exp_fe = n_fe; exp_pe = n_pe;
    for (int r = 0; r < 16; r++) begin
      logic [7:0] d, word;
      logic [2:0] db;
      int nb;
      bit two, has_par;
      logic st1, st2v, pb, po;
      d = 8'($urandom); db = 3'($urandom_range(0, 7));
      nb = (db + 1 < 5) ? 5 : db + 1;
      word = d & 8'((1 << nb) - 1);
      two = ($urandom_range(0, 1) == 1);
      st1 = ($urandom_range(0, 5) != 0);
      st2v = ($urandom_range(0, 5) != 0);
      pb = 1'($urandom); po = 1'($urandom);
      parity_en = 1'($urandom); parity_odd = po;
`ifdef UART_RX_PARITY_EN
      has_par = parity_en;
`else
      has_par = 0;
`endif
      data_bits = db; stop2 = two;
      if (!st1 || (two && !st2v)) exp_fe++;
      else if (has_par && ((^word ^ pb) != po)) exp_pe++;
      else model_q.push_back(word);
      send_frame(d, nb, has_par, pb, two, st1, st2v, 0);
      @(negedge clk);
      chk($sformatf("rnd%0d_ferr", r), n_fe, exp_fe);
      chk($sformatf("rnd%0d_perr", r), n_pe, exp_pe);
      chk($sformatf("rnd%0d_drained", r), model_q.size(), 0);
      chk($sformatf("rnd%0d_count", r), fifo_count, 0);
    end
    mon_chk = 0;
    rx_ready = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
